cordic_rotate_fsm: RTL and testbench

//  Iterative CORDIC in rotation mode. Converts a polar pair (phase, radius) into
//  a cartesian pair (cos, sin), one micro-rotation per clock.

---
 rtl/cordic_rotate_fsm.sv | 170 +++++++++++++++++
 tb/tb_cordic_rotate_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate_fsm.sv
// Iterative rotation-mode CORDIC: (phase, radius) -> (cos, sin), one micro-rotation per clock.
// Latency N_ITER+2 from start to done (N_ITER+3 with CORDIC_GAIN_COMP_EN); no backpressure, start ignored while busy.
module cordic_rotate_fsm #(
  parameter int PHI_W  = 27,
  parameter int R_W    = 25,
  parameter int OUT_W  = 26,
  parameter int ANG_W  = 24,
  parameter int N_ITER = 24,
  parameter int PI     = 8388607
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            start_i,
  input  logic signed [PHI_W-1:0]         phi_i,
  input  logic signed [R_W-1:0]           r_i,
  input  logic [N_ITER-1:0][ANG_W-1:0]    angle_table,
  output logic signed [OUT_W-1:0]         cos_o,
  output logic signed [OUT_W-1:0]         sin_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int CNT_W = $clog2(N_ITER);
  localparam logic signed [PHI_W-1:0] PI_C    = PHI_W'(PI);
  localparam logic signed [PHI_W-1:0] HALF_PI = PHI_W'(PI / 2);
  localparam logic signed [PHI_W-1:0] TWO_PI  = PHI_W'(2 * PI);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, COMP, DONE} state_t;

  state_t state, next_state;

  logic signed [PHI_W-1:0] phi_q, z_q;
  logic signed [R_W-1:0]   r_q;
  logic signed [OUT_W:0]   x_q, y_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last;

  logic signed [PHI_W-1:0] phi_w, z_ld, zn, ang;
  logic signed [OUT_W:0]   r_ext, x_ld, xs, ys, xn, yn;

  assign last = (cnt_q == CNT_W'(N_ITER - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: if (start_i) next_state = LOAD;
      LOAD: begin
        busy_o     = 1'b1;
        next_state = ITER;
      end
      ITER: begin
        busy_o = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
        if (last) next_state = COMP;
`else
        if (last) next_state = DONE;
`endif
      end
      COMP: begin
        busy_o     = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single phase wrap into [-PI, PI], then fold into the CORDIC convergence range.
  always_comb begin
    phi_w = phi_q;
    if (phi_q > PI_C)       phi_w = phi_q - TWO_PI;
    else if (phi_q < -PI_C) phi_w = phi_q + TWO_PI;
    r_ext = (OUT_W + 1)'(r_q);
    x_ld  = r_ext;
    z_ld  = phi_w;
    if (phi_w > HALF_PI) begin
      x_ld = -r_ext;
      z_ld = phi_w - PI_C;
    end else if (phi_w < -HALF_PI) begin
      x_ld = -r_ext;
      z_ld = phi_w + PI_C;
    end
  end

  always_comb begin
    xs  = x_q >>> cnt_q;
    ys  = y_q >>> cnt_q;
    ang = PHI_W'($signed(angle_table[cnt_q]));
    if (!z_q[PHI_W-1]) begin
      xn = x_q - ys;
      yn = y_q + xs;
      zn = z_q - ang;
    end else begin
      xn = x_q + ys;
      yn = y_q - xs;
      zn = z_q + ang;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = OUT_W + 1 + 18;
  localparam logic signed [17:0] KINV = 18'sd39797;
  logic signed [PW-1:0] px, py;
  logic signed [OUT_W:0] xc, yc;
  always_comb begin
    px = PW'(x_q) * PW'(KINV) + PW'(32768);
    py = PW'(y_q) * PW'(KINV) + PW'(32768);
    xc = px[OUT_W+16:16];
    yc = py[OUT_W+16:16];
  end
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phi_q <= '0;
      r_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      cos_o <= '0;
      sin_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          phi_q <= phi_i;
          r_q   <= r_i;
        end
        LOAD: begin
          x_q   <= x_ld;
          y_q   <= '0;
          z_q   <= z_ld;
          cnt_q <= '0;
        end
        ITER: begin
          x_q   <= xn;
          y_q   <= yn;
          z_q   <= zn;
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
`ifndef CORDIC_GAIN_COMP_EN
          if (last) begin
            cos_o <= xn[OUT_W-1:0];
            sin_o <= yn[OUT_W-1:0];
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_q   <= xc;
          y_q   <= yc;
          cos_o <= xc[OUT_W-1:0];
          sin_o <= yc[OUT_W-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotate_fsm.sv
// Scoreboard bench for cordic_rotate_fsm: directed vectors, monitor pops expectations on done_o.
// Expected values follow the CORDIC_GAIN_COMP_EN build setting.
module tb_cordic_rotate_fsm;
  localparam int PHI_W  = 27;
  localparam int R_W    = 25;
  localparam int OUT_W  = 26;
  localparam int ANG_W  = 24;
  localparam int N_ITER = 24;
  localparam int TOL    = 64;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = N_ITER + 3;
`else
  localparam int LAT = N_ITER + 2;
`endif

  logic                         clk_i = 1'b0;
  logic                         reset_ni = 1'b1;
  logic                         start_i = 1'b0;
  logic signed [PHI_W-1:0]      phi_i = '0;
  logic signed [R_W-1:0]        r_i = '0;
  logic [N_ITER-1:0][ANG_W-1:0] angle_table;
  logic signed [OUT_W-1:0]      cos_o, sin_o;
  logic                         busy_o, done_o;

  cordic_rotate_fsm dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .phi_i(phi_i), .r_i(r_i),
    .angle_table(angle_table), .cos_o(cos_o), .sin_o(sin_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int q_cos[$], q_sin[$], q_cyc[$], q_tol[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Hand-computed: K = 1.6467602581 (24 iterations); compensated gain K*39797/65536 = 1.0000018.
  int v_phi[10] = '{0, 4194303, 8388607, -2097151, 12582911, -8388607, 0, 4194303, 6291455, -12582911};
  int v_r[10]   = '{1000000, 1000000, 1000000, 1000000, 1000000, 600000, -500000, 0, 800000, 1000000};
`ifdef CORDIC_GAIN_COMP_EN
  int v_cos[10] = '{1000002, 0, -1000002, 707108, 0, -600001, -500001, 0, -565686, 0};
  int v_sin[10] = '{0, 1000002, 0, -707108, -1000002, 0, 0, 0, 565686, 1000002};
`else
  int v_cos[10] = '{1646760, 0, -1646760, 1164435, 0, -988056, -823380, 0, -931548, 0};
  int v_sin[10] = '{0, 1646760, 0, -1164435, -1646760, 0, 0, 0, 931548, 1646760};
`endif

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  always @(negedge clk_i) begin
    if (done_o) begin
      done_cnt++;
      if (q_cos.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        int ec, es, sc, tl;
        ec = q_cos.pop_front();
        es = q_sin.pop_front();
        sc = q_cyc.pop_front();
        tl = q_tol.pop_front();
        chk("cos", int'(cos_o), ec, tl);
        chk("sin", int'(sin_o), es, tl);
        chk("latency", cyc - sc, LAT, 0);
        chk("busy_at_done", int'(busy_o), 0, 0);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i); #1;
      if (!busy_o && !done_o) return;
    end
    timeout("wait_idle");
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk_i); #1;
      if (done_cnt >= n) return;
    end
    timeout("wait_done");
  endtask

  task automatic issue(input int idx, input bit expect_result);
    start_i = 1'b1;
    phi_i   = PHI_W'(v_phi[idx]);
    r_i     = R_W'(v_r[idx]);
    if (expect_result) begin
      q_cos.push_back(v_cos[idx]);
      q_sin.push_back(v_sin[idx]);
      q_cyc.push_back(cyc);
      q_tol.push_back(v_r[idx] == 0 ? 0 : TOL);
    end
    @(negedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int n;
    wait_idle();
    n = done_cnt + 1;
    issue(idx, 1'b1);
    wait_done(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N_ITER; i++)
      angle_table[i] = ANG_W'($rtoi($atan(1.0 / real'(1 << i)) * 8388607.0 / 3.14159265358979));

    #2 reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_cos", int'(cos_o), 0, 0);
    chk("reset_sin", int'(sin_o), 0, 0);
    chk("reset_busy", int'(busy_o), 0, 0);
    chk("reset_done", int'(done_o), 0, 0);
    reset_ni = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Start pulses during ITER and during the DONE cycle must both be ignored.
    wait_idle();
    n = done_cnt + 1;
    issue(0, 1'b1);
    repeat (8) @(negedge clk_i);
    #1;
    issue(1, 1'b0);
    wait_done(n);
    chk("done_cycle_done", int'(done_o), 1, 0);
    issue(3, 1'b0);
    chk("start_in_done_busy", int'(busy_o), 0, 0);
    repeat (LAT + 5) @(negedge clk_i);
    #1;
    chk("no_extra_done", done_cnt, n, 0);

    // Reset mid-ITER aborts the computation without a done pulse.
    wait_idle();
    n = done_cnt;
    issue(2, 1'b1);
    repeat (10) @(negedge clk_i);
    #1;
    reset_ni = 1'b0;
    #1;
    chk("abort_cos", int'(cos_o), 0, 0);
    chk("abort_sin", int'(sin_o), 0, 0);
    chk("abort_busy", int'(busy_o), 0, 0);
    chk("abort_done", int'(done_o), 0, 0);
    void'(q_cos.pop_back());
    void'(q_sin.pop_back());
    void'(q_cyc.pop_back());
    void'(q_tol.pop_back());
    @(negedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (LAT + 5) @(negedge clk_i);
    #1;
    chk("abort_no_done", done_cnt, n, 0);

    run_vec(3);
    run_vec(8);

    repeat (5) @(negedge clk_i);
    #1;
    chk("scoreboard_drained", q_cos.size(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
